// File: rtl/gate_lane_arbiter_pkg.sv
// Shared types and defaults for the two-lane gate arbiter.
// The state enum is visible to the top, its debug port and the bench.
package gate_lane_arbiter_pkg;

  localparam int PIN_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 1000;
  localparam int TMR_W_DEF   = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_PASS    = 3'd2,
    ST_DONE_OK = 3'd3,
    ST_REJECT  = 3'd4,
    ST_LOCK    = 3'd5
  } state_t;

  // A lane owns the gatemanager only while waiting for it or passing through it.
  function automatic logic is_busy(input state_t s);
    return (s == ST_WAIT) || (s == ST_PASS);
  endfunction

endpackage

// File: rtl/gate_lane_arbiter_if.sv
// Bundle of lane and gatemanager signals around the arbiter.
// master = lanes + gatemanager side, slave = the arbiter itself.
interface gate_lane_arbiter_if
  import gate_lane_arbiter_pkg::*;
#(
  parameter int PIN_W = PIN_W_DEF
);

  // Handshake: a lane raises req with its PIN ready and holds it for the whole
  // transaction; gnt stays high from one cycle after req is seen until the
  // end cycle, where gnt drops and done pulses once with ok qualifying it.
  logic             req0;
  logic             req1;
  logic [PIN_W-1:0] pin0;
  logic [PIN_W-1:0] pin1;
  logic             s02_0;
  logic             s02_1;
  logic             gnt0;
  logic             gnt1;
  logic             done;
  logic             ok;
  logic             gm_s01;
  logic [PIN_W-1:0] gm_pass;
  logic             gm_s02;
  logic             gm_gate;
  logic             gm_wrong_pin;
  logic             gm_lock;
  logic             lock_out;

  modport master (
    output req0, req1, pin0, pin1, s02_0, s02_1,
    output gm_gate, gm_wrong_pin, gm_lock,
    input  gnt0, gnt1, done, ok, gm_s01, gm_pass, gm_s02, lock_out
  );

  modport slave (
    input  req0, req1, pin0, pin1, s02_0, s02_1,
    input  gm_gate, gm_wrong_pin, gm_lock,
    output gnt0, gnt1, done, ok, gm_s01, gm_pass, gm_s02, lock_out
  );

endinterface

// File: rtl/gate_lane_arbiter_rr_arbiter_2.sv
// Two-way round-robin picker. ptr names the lane that wins a tie; on advance
// it moves away from the lane currently granted so that lane loses next tie.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  assign gnt[0] = req[0] & (~req[1] | ~ptr);
  assign gnt[1] = req[1] & ~gnt[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/gate_lane_arbiter.sv
// Shares one gatemanager between two entry lanes: grants a lane, forwards its
// PIN and exit sensor, and reports passed / rejected / locked back to the lane.
module gate_lane_arbiter
  import gate_lane_arbiter_pkg::*;
#(
  parameter int PIN_W   = PIN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TMR_W   = TMR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  gate_lane_arbiter_if.slave  bus,
  output state_t              dbg_state
);

  state_t           state;
  state_t           state_n;
  logic             lane;
  logic             lane_n;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_n;

  logic             gnt0_q;
  logic             gnt1_q;
  logic             done_q;
  logic             ok_q;
  logic             s01_q;
  logic [PIN_W-1:0] pass_q;
  logic             s02_q;
  logic             lock_q;

  logic [1:0]       arb_req;
  logic [1:0]       arb_gnt;
  logic             advance;
  logic             lane_req;
  logic             lane_s02;
  logic             timeout_hit;
  logic             busy_n;

  assign lane_req    = lane ? bus.req1 : bus.req0;
  assign lane_s02    = lane_n ? bus.s02_1 : bus.s02_0;
  assign timeout_hit = (timer == TMR_W'(TIMEOUT - 1));
  assign advance     = (state == ST_DONE_OK) || (state == ST_REJECT);
  assign busy_n      = is_busy(state_n);

  // Outside IDLE the arbiter only sees the lane being served, so the
  // pointer update at the end cycle is taken against that lane.
  assign arb_req = (state == ST_IDLE) ? {bus.req1, bus.req0}
                                      : (lane ? 2'b10 : 2'b01);

  rr_arbiter_2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (advance),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_n = state;
    lane_n  = lane;
    timer_n = timer;
    if (is_busy(state) && (timer != {TMR_W{1'b1}})) begin
      timer_n = timer + 1'b1;
    end
    case (state)
      ST_IDLE: begin
        if (|arb_gnt) begin
          state_n = ST_WAIT;
          lane_n  = arb_gnt[1];
          timer_n = '0;
        end
      end
      ST_WAIT: begin
        if (bus.gm_lock) begin
          state_n = ST_LOCK;
        end else if (!lane_req) begin
          state_n = ST_REJECT;
        end else if (bus.gm_wrong_pin) begin
          state_n = ST_REJECT;
        end else if (bus.gm_gate) begin
          state_n = ST_PASS;
          timer_n = '0;
        end else if (timeout_hit) begin
          state_n = ST_REJECT;
        end
      end
      ST_PASS: begin
        // Entry into PASS required gate high, so gate low here is its fall.
        if (bus.gm_lock) begin
          state_n = ST_LOCK;
        end else if (!lane_req) begin
          state_n = ST_REJECT;
        end else if (!bus.gm_gate) begin
          state_n = ST_DONE_OK;
        end else if (timeout_hit) begin
          state_n = ST_REJECT;
        end
      end
      ST_DONE_OK: state_n = ST_IDLE;
      ST_REJECT:  state_n = ST_IDLE;
      ST_LOCK:    state_n = ST_LOCK;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      lane   <= 1'b0;
      timer  <= '0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      s01_q  <= 1'b0;
      pass_q <= '0;
      s02_q  <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      state  <= state_n;
      lane   <= lane_n;
      timer  <= timer_n;
      gnt0_q <= busy_n & ~lane_n;
      gnt1_q <= busy_n & lane_n;
      s01_q  <= busy_n;
      s02_q  <= (state_n == ST_PASS) & lane_s02;
      done_q <= (state_n == ST_DONE_OK) || (state_n == ST_REJECT);
      ok_q   <= (state_n == ST_DONE_OK);
      lock_q <= (state_n == ST_LOCK);
      // PIN is captured once at grant and held; later pin changes are ignored.
      if (!busy_n) begin
        pass_q <= '0;
      end else if (state == ST_IDLE) begin
        pass_q <= lane_n ? bus.pin1 : bus.pin0;
      end
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done     = done_q;
  assign bus.ok       = ok_q;
  assign bus.gm_s01   = s01_q;
  assign bus.gm_pass  = pass_q;
  assign bus.gm_s02   = s02_q;
  assign bus.lock_out = lock_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_gate_lane_arbiter.sv
// Bench for gate_lane_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level model of the lane/gate rules.
module tb_gate_lane_arbiter;
  import gate_lane_arbiter_pkg::*;

  localparam int PIN_W   = 16;
  localparam int TIMEOUT = 8;
  localparam int TMR_W   = 10;
  localparam int OBS_W   = 7 + PIN_W;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     sb_on = 1'b0;

  logic [OBS_W-1:0] exp_q[$];

  gate_lane_arbiter_if #(.PIN_W(PIN_W)) bus ();

  gate_lane_arbiter #(
    .PIN_W   (PIN_W),
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int               m_owner;     // -1 = nobody served, else lane index
  bit               m_gate_open;
  bit               m_locked;
  bit               m_done_now;
  bit               m_ok_now;
  int               m_prefer;    // lane that wins a tie
  int               m_start;     // first cycle of current wait/pass window
  logic [PIN_W-1:0] m_pin;
  bit               m_s02;

  task automatic m_finish(input bit ok_v);
    m_done_now  = 1'b1;
    m_ok_now    = ok_v;
    m_prefer    = 1 - m_owner;
    m_owner     = -1;
    m_gate_open = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit r0, input bit r1,
                            input logic [PIN_W-1:0] p0, input logic [PIN_W-1:0] p1,
                            input bit s0, input bit s1, input bit g, input bit w,
                            input bit l);
    bit own_req;
    int elapsed;
    if (r) begin
      m_owner = -1; m_gate_open = 0; m_locked = 0; m_done_now = 0;
      m_ok_now = 0; m_prefer = 0; m_pin = '0;
    end else if (m_locked) begin
      m_done_now = 0;
    end else if (m_done_now) begin
      m_done_now = 0;
    end else if (m_owner < 0) begin
      if (r0 || r1) begin
        m_owner     = (r0 && r1) ? m_prefer : (r0 ? 0 : 1);
        m_pin       = (m_owner == 1) ? p1 : p0;
        m_gate_open = 0;
        m_start     = cyc + 1;
      end
    end else begin
      own_req = (m_owner == 1) ? r1 : r0;
      elapsed = cyc - m_start;
      if (l) begin
        m_locked = 1; m_owner = -1; m_gate_open = 0;
      end else if (!own_req) begin
        m_finish(1'b0);
      end else if (!m_gate_open) begin
        if (w) m_finish(1'b0);
        else if (g) begin m_gate_open = 1; m_start = cyc + 1; end
        else if (elapsed == TIMEOUT - 1) m_finish(1'b0);
      end else begin
        if (!g) m_finish(1'b1);
        else if (elapsed == TIMEOUT - 1) m_finish(1'b0);
      end
    end
    m_s02 = (m_owner >= 0) && m_gate_open && ((m_owner == 1) ? s1 : s0);
  endtask

  function automatic logic [6:0] model_obs();
    return {m_owner == 0, m_owner == 1, m_owner >= 0, m_s02,
            m_done_now, m_done_now && m_ok_now, m_locked};
  endfunction

  // ---------------- driver ----------------
  function automatic logic [6:0] obs();
    return {bus.gnt0, bus.gnt1, bus.gm_s01, bus.gm_s02, bus.done, bus.ok, bus.lock_out};
  endfunction

  task automatic tick();
    bit r, r0, r1, s0, s1, g, w, l;
    logic [PIN_W-1:0] p0, p1;
    r = rst; r0 = bus.req0; r1 = bus.req1; p0 = bus.pin0; p1 = bus.pin1;
    s0 = bus.s02_0; s1 = bus.s02_1; g = bus.gm_gate; w = bus.gm_wrong_pin; l = bus.gm_lock;
    @(posedge clk);
    model_edge(r, r0, r1, p0, p1, s0, s1, g, w, l);
    cyc++;
    if (sb_on) exp_q.push_back({model_obs(), (m_owner >= 0) ? m_pin : {PIN_W{1'b0}}});
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.pin0 = '0; bus.pin1 = '0;
    bus.s02_0 = 0; bus.s02_1 = 0; bus.gm_gate = 0; bus.gm_wrong_pin = 0; bus.gm_lock = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; bus.req0 = 1; bus.req1 = 1; bus.gm_gate = 1;
    tick(); tick();
    checks++; if (obs() !== 7'b0) begin errors++; $display("FAIL reset_outputs got %b want %b", obs(), 7'b0); end
    checks++; if (bus.gm_pass !== '0) begin errors++; $display("FAIL reset_pass got %h want 0", bus.gm_pass); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); end
    clear_inputs(); rst = 0; tick();
    checks++; if (obs() !== 7'b0) begin errors++; $display("FAIL reset_idle got %b want %b", obs(), 7'b0); end
  endtask

  task automatic test_single_pass();
    bus.req0 = 1; bus.pin0 = 16'h4037; tick();
    checks++; if (obs() !== 7'b1010000) begin errors++; $display("FAIL single_grant got %b want %b", obs(), 7'b1010000); end
    checks++; if (bus.gm_pass !== 16'h4037) begin errors++; $display("FAIL single_pin got %h want 4037", bus.gm_pass); end
    bus.pin0 = 16'h1111; tick(); tick();
    checks++; if (bus.gm_pass !== 16'h4037) begin errors++; $display("FAIL single_pin_hold got %h want 4037", bus.gm_pass); end
    for (int i = 0; i < 5; i++) begin
      bus.gm_gate = 1; bus.s02_0 = i[0]; tick();
      checks++;
      if (obs() !== {4'b1010 | {3'b000, i[0]}, 3'b000}) begin
        errors++; $display("FAIL single_pass_s02 got %b want %b", obs(), {4'b1010 | {3'b000, i[0]}, 3'b000});
      end
    end
    bus.gm_gate = 0; bus.s02_0 = 1; tick();
    checks++; if (obs() !== 7'b0000110) begin errors++; $display("FAIL single_done_ok got %b want %b", obs(), 7'b0000110); end
    clear_inputs(); tick();
    checks++; if (obs() !== 7'b0) begin errors++; $display("FAIL single_after got %b want %b", obs(), 7'b0); end
  endtask

  task automatic test_back_to_back();
    rst = 1; tick(); rst = 0;
    bus.req0 = 1; bus.req1 = 1; bus.pin0 = 16'hAAAA; bus.pin1 = 16'h5555; tick();
    checks++; if (obs() !== 7'b1010000) begin errors++; $display("FAIL b2b_first got %b want %b", obs(), 7'b1010000); end
    checks++; if (bus.gm_pass !== 16'hAAAA) begin errors++; $display("FAIL b2b_pin0 got %h want aaaa", bus.gm_pass); end
    bus.gm_gate = 1; tick(); bus.s02_0 = 1; tick();
    checks++; if (obs() !== 7'b1011000) begin errors++; $display("FAIL b2b_s02 got %b want %b", obs(), 7'b1011000); end
    bus.gm_gate = 0; bus.s02_0 = 0; tick();
    checks++; if (obs() !== 7'b0000110) begin errors++; $display("FAIL b2b_done0 got %b want %b", obs(), 7'b0000110); end
    tick();
    checks++; if (obs() !== 7'b0) begin errors++; $display("FAIL b2b_gap got %b want %b", obs(), 7'b0); end
    tick();
    checks++; if (obs() !== 7'b0110000) begin errors++; $display("FAIL b2b_second got %b want %b", obs(), 7'b0110000); end
    checks++; if (bus.gm_pass !== 16'h5555) begin errors++; $display("FAIL b2b_pin1 got %h want 5555", bus.gm_pass); end
    bus.gm_gate = 1; tick(); bus.gm_gate = 0; tick();
    checks++; if (obs() !== 7'b0000110) begin errors++; $display("FAIL b2b_done1 got %b want %b", obs(), 7'b0000110); end
    clear_inputs(); tick();
  endtask

  task automatic test_wrong_pin();
    bus.req0 = 1; bus.req1 = 1; tick();
    checks++; if (obs() !== 7'b1010000) begin errors++; $display("FAIL wp_grant0 got %b want %b", obs(), 7'b1010000); end
    bus.gm_wrong_pin = 1; tick();
    checks++; if (obs() !== 7'b0000100) begin errors++; $display("FAIL wp_reject0 got %b want %b", obs(), 7'b0000100); end
    bus.gm_wrong_pin = 0; tick(); tick();
    checks++; if (obs() !== 7'b0110000) begin errors++; $display("FAIL wp_other_lane got %b want %b", obs(), 7'b0110000); end
    bus.gm_wrong_pin = 1; tick();
    checks++; if (obs() !== 7'b0000100) begin errors++; $display("FAIL wp_reject1 got %b want %b", obs(), 7'b0000100); end
    clear_inputs(); tick();
  endtask

  task automatic test_timeout_abort();
    int n;
    bit found;
    bus.req0 = 1; tick();
    n = 0; found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (bus.done === 1'b1) begin found = 1; n = i; end
    end
    checks++; if (n !== TIMEOUT) begin errors++; $display("FAIL timeout_latency got %0d want %0d", n, TIMEOUT); end
    checks++; if (bus.ok !== 1'b0) begin errors++; $display("FAIL timeout_ok got %b want 0", bus.ok); end
    tick(); tick();
    checks++; if (obs() !== 7'b1010000) begin errors++; $display("FAIL abort_grant got %b want %b", obs(), 7'b1010000); end
    bus.gm_gate = 1; tick(); bus.req0 = 0; tick();
    checks++; if (obs() !== 7'b0000100) begin errors++; $display("FAIL abort_reject got %b want %b", obs(), 7'b0000100); end
    clear_inputs(); tick();
  endtask

  task automatic test_reset_mid();
    bus.req0 = 1; tick(); bus.gm_gate = 1; bus.s02_0 = 1; tick();
    checks++; if (obs() !== 7'b1011000) begin errors++; $display("FAIL rstmid_pass got %b want %b", obs(), 7'b1011000); end
    rst = 1; tick();
    checks++; if ({obs(), bus.gm_pass} !== '0) begin errors++; $display("FAIL rstmid_clear got %b/%h want 0", obs(), bus.gm_pass); end
    rst = 0; bus.gm_gate = 0; bus.s02_0 = 0; bus.req1 = 1; tick();
    checks++; if (obs() !== 7'b1010000) begin errors++; $display("FAIL rstmid_lane0_prio got %b want %b", obs(), 7'b1010000); end
    clear_inputs(); tick(); tick();
  endtask

  task automatic test_lock();
    bus.req0 = 1; tick();
    bus.gm_lock = 1; bus.gm_gate = 1; tick();
    checks++; if (obs() !== 7'b0000001) begin errors++; $display("FAIL lock_enter got %b want %b", obs(), 7'b0000001); end
    bus.gm_lock = 0; bus.gm_gate = 0; bus.req1 = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({obs(), bus.gm_pass} !== {7'b0000001, {PIN_W{1'b0}}}) begin
        errors++; $display("FAIL lock_sticky got %b/%h want 0000001/0", obs(), bus.gm_pass);
      end
    end
    rst = 1; tick(); rst = 0;
    checks++; if (obs() !== 7'b0) begin errors++; $display("FAIL lock_cleared got %b want %b", obs(), 7'b0); end
    clear_inputs(); tick();
  endtask

  task automatic test_random();
    logic [OBS_W-1:0] got;
    logic [OBS_W-1:0] want;
    int lock_cycles;
    lock_cycles = 0;
    exp_q.delete();
    sb_on = 1;
    rst = 1; tick(); rst = 0;
    void'(exp_q.pop_front());
    for (int i = 0; i < 1500; i++) begin
      if (m_locked) lock_cycles++;
      rst = (lock_cycles > 12) || ($urandom_range(0, 299) == 0);
      if (rst) lock_cycles = 0;
      if ($urandom_range(0, 11) == 0) bus.req0 = ~bus.req0;
      if ($urandom_range(0, 11) == 0) bus.req1 = ~bus.req1;
      if ($urandom_range(0, 4) == 0) bus.gm_gate = ~bus.gm_gate;
      bus.pin0 = PIN_W'($urandom);
      bus.pin1 = PIN_W'($urandom);
      bus.s02_0 = 1'($urandom_range(0, 1));
      bus.s02_1 = 1'($urandom_range(0, 1));
      bus.gm_wrong_pin = ($urandom_range(0, 39) == 0);
      bus.gm_lock = ($urandom_range(0, 399) == 0);
      tick();
      got = {obs(), bus.gm_pass};
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL rand_queue_empty at cycle %0d", cyc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++; $display("FAIL rand_outputs cycle %0d got %b want %b", cyc, got, want);
        end
      end
      checks++;
      if ((bus.gnt0 & bus.gnt1) !== 1'b0) begin
        errors++; $display("FAIL rand_onehot got %b%b want not both", bus.gnt0, bus.gnt1);
      end
      checks++;
      if ((dbg_state == ST_IDLE) && (bus.done !== 1'b0)) begin
        errors++; $display("FAIL rand_done_in_idle got %b want 0", bus.done);
      end
    end
    sb_on = 0;
    rst = 0; clear_inputs();
  endtask

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_single_pass();
    test_back_to_back();
    test_wrong_pin();
    test_timeout_abort();
    test_reset_mid();
    test_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
